// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared types and constants for the ALU serial command link
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } alu_op_t;

  typedef enum logic {
    PKT_DATA = 1'b0,
    PKT_CMD  = 1'b1
  } pkt_type_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TYPE    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_STOP    = 3'd3,
    S_RESYNC  = 3'd4
  } rx_state_t;

  localparam logic [3:0] CRC4_POLY = 4'b0011;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc4_serial.sv
// ---------------------------------------------------------------------------
// crc4_serial : bit-serial CRC4 (x^4+x+1), init 0, clear has priority
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crc4_serial
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       d_i,
  output logic [3:0] crc_o
);

  logic [3:0] crc_q;
  logic [3:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[3] ^ d_i;
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = 4'b0000;
    end else if (enable_i) begin
      crc_d = {crc_q[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 4'b0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/alu_frame_rx.sv
// ---------------------------------------------------------------------------
// alu_frame_rx : sin-protocol responder; deserialises DATA/CMD packets into
//                one decoded (B, A, OP) command with error flags per frame
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_frame_rx
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic              frame_valid,
  output logic [DATA_W-1:0] frame_a,
  output logic [DATA_W-1:0] frame_b,
  output logic [2:0]        frame_op,
  output logic [2:0]        frame_err,
  output logic              frame_abort,
  output logic              busy
);

  localparam int N_DATA = 2 * DATA_W / 8;
  localparam int CNT_W  = $clog2(N_DATA + 2);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(N_DATA);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(N_DATA + 1);

  rx_state_t             state_q,  state_d;
  pkt_type_t             type_q,   type_d;
  logic [2:0]            bit_q,    bit_d;
  logic [7:0]            pay_q,    pay_d;
  logic [2*DATA_W-1:0]   shreg_q,  shreg_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic                  valid_q,  valid_d;
  logic                  abort_q,  abort_d;
  logic [DATA_W-1:0]     a_q,      a_d;
  logic [DATA_W-1:0]     b_q,      b_d;
  logic [2:0]            op_q,     op_d;
  logic [2:0]            err_q,    err_d;

  logic                  crc_clr;
  logic                  crc_en;
  logic                  crc_din;
  logic [3:0]            crc_val;

  crc4_serial u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (crc_clr),
    .enable_i (crc_en),
    .d_i      (crc_din),
    .crc_o    (crc_val)
  );

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    bit_d   = bit_q;
    pay_d   = pay_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    err_d   = err_q;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = sin;

    case (state_q)
      S_IDLE: begin
        if (!sin) state_d = S_TYPE;
      end

      S_TYPE: begin
        type_d  = pkt_type_t'(sin);
        bit_d   = 3'd7;
        state_d = S_PAYLOAD;
      end

      S_PAYLOAD: begin
        pay_d = {pay_q[6:0], sin};
        // CMD bit 7 is the fixed separator 1; the CRC field itself is not fed
        if (type_q == PKT_DATA) begin
          crc_en = (cnt_q <= C_CNT_FULL);
        end else begin
          crc_en  = (bit_q >= 3'd4) && (cnt_q <= C_CNT_FULL);
          crc_din = (bit_q == 3'd7) ? 1'b1 : sin;
        end
        if (bit_q == 3'd0) begin
          state_d = S_STOP;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end

      S_STOP: begin
        if (sin) begin
          state_d = S_IDLE;
          if (type_q == PKT_DATA) begin
            shreg_d = {shreg_q[2*DATA_W-9:0], pay_q};
            if (cnt_q != C_CNT_SAT) cnt_d = cnt_q + 1'b1;
          end else begin
            valid_d = 1'b1;
            a_d     = shreg_q[DATA_W-1:0];
            b_d     = shreg_q[2*DATA_W-1:DATA_W];
            op_d    = pay_q[6:4];
            err_d   = 3'b000;
            if (cnt_q != C_CNT_FULL) begin
              err_d[ERR_DATA_BIT] = 1'b1;
            end else begin
              err_d[ERR_CRC_BIT] = (crc_val != pay_q[3:0]);
              err_d[ERR_OP_BIT]  = !op_is_legal(pay_q[6:4]);
            end
            cnt_d   = '0;
            crc_clr = 1'b1;
          end
        end else begin
          state_d = S_RESYNC;
          abort_d = 1'b1;
          shreg_d = '0;
          pay_d   = 8'h00;
          cnt_d   = '0;
          crc_clr = 1'b1;
        end
      end

      S_RESYNC: begin
        if (sin) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      type_q  <= PKT_DATA;
      bit_q   <= 3'd0;
      pay_q   <= 8'h00;
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      err_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      bit_q   <= bit_d;
      pay_q   <= pay_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_abort = abort_q;
  assign frame_a     = a_q;
  assign frame_b     = b_q;
  assign frame_op    = op_q;
  assign frame_err   = err_q;
  // Stays high across inter-packet gaps while a frame is partly received
  assign busy        = (state_q == S_TYPE) || (state_q == S_PAYLOAD) ||
                       (state_q == S_STOP) || (cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_alu_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_alu_frame_rx : directed and randomised checks of alu_frame_rx
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_frame_rx;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sin;
  logic              frame_valid;
  logic [DATA_W-1:0] frame_a;
  logic [DATA_W-1:0] frame_b;
  logic [2:0]        frame_op;
  logic [2:0]        frame_err;
  logic              frame_abort;
  logic              busy;

  int tests = 0;
  int fails = 0;

  logic [69:0] got_q[$];
  int          abort_cnt = 0;
  bit          overlap   = 1'b0;

  alu_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .frame_valid (frame_valid),
    .frame_a     (frame_a),
    .frame_b     (frame_b),
    .frame_op    (frame_op),
    .frame_err   (frame_err),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Record every decoded frame and abort pulse shortly after the edge
  always @(posedge clk) begin
    #1;
    if (frame_valid) got_q.push_back({frame_err, frame_op, frame_b, frame_a});
    if (frame_abort) abort_cnt++;
    if (frame_valid && frame_abort) overlap = 1'b1;
  end

  function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] op);
    logic [3:0]  c;
    logic [67:0] s;
    logic        fb;
    c = 4'b0000;
    s = {b, a, 1'b1, op};
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ s[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  task automatic send_packet(input logic typ, input logic [7:0] pay, input logic stop);
    logic [10:0] bits;
    bits = {1'b0, typ, pay, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk) sin = bits[i];
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc_x, input int ndata);
    logic [63:0] ba;
    logic [7:0]  byte_v;
    ba = {b, a};
    for (int i = 0; i < ndata; i++) begin
      byte_v = (i < 8) ? ba[63-8*i -: 8] : 8'hA5;
      send_packet(1'b0, byte_v, 1'b1);
    end
    send_packet(1'b1, {1'b0, op, crc_ref(b, a, op) ^ crc_x}, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) sin = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    tests++; if (frame_abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %b expected 0", frame_abort); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if ({frame_a, frame_b} !== 64'h0) begin fails++; $display("FAIL reset_ab: got %h expected 0", {frame_a, frame_b}); end
    tests++; if ({frame_op, frame_err} !== 6'h0) begin fails++; $display("FAIL reset_op_err: got %b expected 0", {frame_op, frame_err}); end
    rst_n = 1'b1;
    idle(3);
    tests++; if (busy !== 1'b0 || frame_valid !== 1'b0) begin fails++; $display("FAIL idle_after_reset: busy %b valid %b expected 0 0", busy, frame_valid); end
  endtask

  task automatic test_basic;
    logic [69:0] g;
    got_q.delete();
    send_frame(32'd2, 32'd1, 3'b100, 4'h0, 8);
    @(negedge clk) sin = 1'b1;
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: valid %b expected 1", frame_valid); end
    @(negedge clk) sin = 1'b1;
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL basic_pulse: valid %b expected 0", frame_valid); end
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL basic_count: got %0d frames expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== {3'b000, 3'b100, 32'd2, 32'd1}) begin
        fails++; $display("FAIL basic_frame: got err %b op %b b %h a %h expected 000 100 00000002 00000001",
                          g[69:67], g[66:64], g[63:32], g[31:0]);
      end
    end
  endtask

  task automatic test_crc_err;
    logic [69:0] g;
    got_q.delete();
    send_frame(32'd2, 32'd1, 3'b100, 4'b0001, 8);
    idle(2);
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL crc_count: got %0d frames expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g[69:67] !== 3'b010) begin fails++; $display("FAIL crc_err: got %b expected 010", g[69:67]); end
      tests++;
      if (g[66:0] !== {3'b100, 32'd2, 32'd1}) begin fails++; $display("FAIL crc_fields: got %h expected %h", g[66:0], {3'b100, 32'd2, 32'd1}); end
    end
  endtask

  task automatic test_data_count;
    logic [69:0] g;
    got_q.delete();
    send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 4'h0, 7);
    idle(2);
    send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 4'h0, 9);
    idle(2);
    send_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, 4'h0, 8);
    idle(2);
    tests++;
    if (got_q.size() != 3) begin
      fails++; $display("FAIL count_frames: got %0d frames expected 3", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g[69:67] !== 3'b100) begin fails++; $display("FAIL count_7data: got %b expected 100", g[69:67]); end
      g = got_q.pop_front();
      tests++;
      if (g[69:67] !== 3'b100) begin fails++; $display("FAIL count_9data: got %b expected 100", g[69:67]); end
      g = got_q.pop_front();
      tests++;
      if (g !== {3'b000, 3'b101, 32'h1234_5678, 32'h9ABC_DEF0}) begin
        fails++; $display("FAIL count_recover: got %h expected %h", g, {3'b000, 3'b101, 32'h1234_5678, 32'h9ABC_DEF0});
      end
    end
  endtask

  task automatic test_bad_op;
    logic [69:0] g;
    got_q.delete();
    send_frame(32'h0000_00FF, 32'hCAFE_0001, 3'b010, 4'h0, 8);
    idle(2);
    send_frame(32'h0000_00FF, 32'hCAFE_0001, 3'b111, 4'b1000, 8);
    idle(2);
    tests++;
    if (got_q.size() != 2) begin
      fails++; $display("FAIL op_count: got %0d frames expected 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g[69:64] !== 6'b001_010) begin fails++; $display("FAIL op_illegal: got err %b op %b expected 001 010", g[69:67], g[66:64]); end
      g = got_q.pop_front();
      tests++;
      if (g[69:67] !== 3'b011) begin fails++; $display("FAIL op_and_crc: got %b expected 011", g[69:67]); end
    end
  endtask

  task automatic test_abort;
    logic [69:0] g;
    int          ab0;
    got_q.delete();
    ab0 = abort_cnt;
    send_packet(1'b0, 8'h11, 1'b1);
    send_packet(1'b0, 8'h22, 1'b1);
    send_packet(1'b0, 8'h33, 1'b1);
    idle(1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_mid: got %b expected 1", busy); end
    send_packet(1'b0, 8'h44, 1'b0);
    @(negedge clk) sin = 1'b1;
    tests++; if (frame_abort !== 1'b1) begin fails++; $display("FAIL abort_pulse: got %b expected 1", frame_abort); end
    idle(3);
    tests++;
    if (abort_cnt != ab0 + 1 || got_q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_effect: aborts %0d frames %0d busy %b expected 1 0 0", abort_cnt - ab0, got_q.size(), busy);
    end
    send_frame(32'h2222_2222, 32'h1111_1111, 3'b001, 4'h0, 8);
    idle(2);
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL abort_recover_count: got %0d frames expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== {3'b000, 3'b001, 32'h2222_2222, 32'h1111_1111}) begin
        fails++; $display("FAIL abort_recover: got %h expected %h", g, {3'b000, 3'b001, 32'h2222_2222, 32'h1111_1111});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [69:0] g;
    logic [63:0] ba;
    logic [10:0] bits;
    got_q.delete();
    ba = {32'h6666_6666, 32'h5555_5555};
    for (int i = 0; i < 8; i++) send_packet(1'b0, ba[63-8*i -: 8], 1'b1);
    bits = {1'b0, 1'b1, 1'b0, 3'b100, 4'h0, 1'b1};
    for (int i = 10; i >= 6; i--) @(negedge clk) sin = bits[i];
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({frame_a, frame_b, frame_op, frame_err, frame_valid, frame_abort, busy} !== 73'h0) begin
      fails++; $display("FAIL reset_async: a %h b %h op %b err %b valid %b busy %b expected all 0",
                        frame_a, frame_b, frame_op, frame_err, frame_valid, busy);
    end
    @(negedge clk) begin rst_n = 1'b1; sin = 1'b1; end
    idle(2);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL reset_no_frame: got %0d frames expected 0", got_q.size()); end
    send_frame(32'd7, 32'd9, 3'b100, 4'h0, 8);
    idle(2);
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL reset_recover_count: got %0d frames expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== {3'b000, 3'b100, 32'd7, 32'd9}) begin
        fails++; $display("FAIL reset_recover: got %h expected %h", g, {3'b000, 3'b100, 32'd7, 32'd9});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [69:0] g;
    got_q.delete();
    send_frame(32'h0123_4567, 32'hDEAD_BEEF, 3'b101, 4'h0, 8);
    send_frame(32'h0, 32'h0, 3'b000, 4'b0100, 8);
    idle(2);
    tests++;
    if (got_q.size() != 2) begin
      fails++; $display("FAIL b2b_count: got %0d frames expected 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== {3'b000, 3'b101, 32'h0123_4567, 32'hDEAD_BEEF}) begin
        fails++; $display("FAIL b2b_first: got %h expected %h", g, {3'b000, 3'b101, 32'h0123_4567, 32'hDEAD_BEEF});
      end
      g = got_q.pop_front();
      tests++;
      if (g !== {3'b010, 3'b000, 64'h0}) begin
        fails++; $display("FAIL b2b_second: got %h expected %h", g, {3'b010, 3'b000, 64'h0});
      end
    end
  endtask

  task automatic test_random;
    logic [69:0] g;
    logic [69:0] exp_v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  cx;
    logic        op_bad;
    got_q.delete();
    for (int n = 0; n < 150; n++) begin
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      cx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      op_bad = !(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101);
      exp_v  = {1'b0, (cx != 4'h0), op_bad, op, b, a};
      send_frame(b, a, op, cx, 8);
      idle(1);
      tests++;
      if (got_q.size() != 1) begin
        fails++; $display("FAIL rand_count[%0d]: got %0d frames expected 1", n, got_q.size());
        got_q.delete();
      end else begin
        g = got_q.pop_front();
        if (g !== exp_v) begin
          fails++; $display("FAIL rand_frame[%0d]: got %h expected %h", n, g, exp_v);
        end
      end
    end
    tests++; if (overlap) begin fails++; $display("FAIL valid_abort_overlap: got 1 expected 0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_crc_err();
    test_data_count();
    test_bad_op();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
